// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between FIFO-buffered CPU writes and priority scanout reads.
// Optional feature: define VRAM_ARB_DROP_CNT_EN to add the drop_count output (discarded out-of-range pushes).
module vram_arbiter #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          STARVE_LIMIT = 8,
    parameter logic [14:0] VRAM_TOP     = 15'h7530
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr_req,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic        cpu_ready,
    input  logic        scan_req,
    input  logic [14:0] scan_addr,
    output logic [7:0]  scan_data,
    output logic        scan_valid,
    output logic [14:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    output logic        vram_re,
    input  logic [7:0]  vram_rdata
`ifdef VRAM_ARB_DROP_CNT_EN
    ,
    output logic [7:0]  drop_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RD, RDATA, WR} state_t;

    state_t        state_q, state_d;
    logic [14:0]   fifo_addr_q [FIFO_DEPTH];
    logic [7:0]    fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [7:0]    starve_q, starve_d;
    logic [14:0]   vram_addr_q, vram_addr_d;
    logic [7:0]    vram_wdata_q, vram_wdata_d, scan_data_q, scan_data_d;
    logic          vram_we_q, vram_we_d, vram_re_q, vram_re_d, scan_valid_q, scan_valid_d;
    logic          empty, full, take, push, pop;

    assign empty      = count_q == '0;
    assign full       = count_q == (AW+1)'(FIFO_DEPTH);
    assign cpu_ready  = !rst && !full;
    assign take       = cpu_wr_req && cpu_ready;
    assign push       = take && (cpu_addr <= VRAM_TOP);
    assign pop        = state_d == WR;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;
    assign vram_we    = vram_we_q;
    assign vram_re    = vram_re_q;
    assign scan_data  = scan_data_q;
    assign scan_valid = scan_valid_q;

    // Grant selection in IDLE: starved writes, then scan (never in its own valid cycle), then writes
    always_comb begin
        state_d = state_q == RD ? RDATA :
                  state_q != IDLE ? IDLE :
                  (!empty && starve_q == 8'(STARVE_LIMIT)) ? WR :
                  (scan_req && !scan_valid_q) ? RD :
                  !empty ? WR : IDLE;
    end

    // Output and starvation next values, computed from the state being entered
    always_comb begin
        vram_re_d    = state_d == RD;
        vram_we_d    = state_d == WR;
        vram_addr_d  = state_d == RD ? scan_addr : state_d == WR ? fifo_addr_q[rd_ptr_q] : vram_addr_q;
        vram_wdata_d = state_d == WR ? fifo_data_q[rd_ptr_q] : vram_wdata_q;
        scan_valid_d = state_q == RDATA;
        scan_data_d  = state_q == RDATA ? vram_rdata : scan_data_q;
        starve_d     = (empty || pop) ? 8'd0 :
                       (state_d == RD && starve_q != 8'(STARVE_LIMIT)) ? starve_q + 8'd1 : starve_q;
    end

    // State, registered outputs and starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vram_re_q    <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
            scan_valid_q <= 1'b0;
            scan_data_q  <= '0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            vram_re_q    <= vram_re_d;
            vram_we_q    <= vram_we_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            scan_valid_q <= scan_valid_d;
            scan_data_q  <= scan_data_d;
            starve_q     <= starve_d;
        end
    end

    // FIFO pointers and occupancy; dropped pushes never enter the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // FIFO storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_data;
        end
    end

`ifdef VRAM_ARB_DROP_CNT_EN
    logic [7:0] drop_q;
    assign drop_count = drop_q;

    // Saturating count of accepted-but-discarded out-of-range pushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= '0;
        else if (take && cpu_addr > VRAM_TOP && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
`endif
endmodule
